// File: rtl/trace_fmt_pkg.sv
// Shared constants and types for the TPIU trace formatter.
package trace_fmt_pkg;

    // Sync units, byte 0 in the low bits so they shift out low nibble first.
    localparam logic [31:0] FULL_SYNC    = 32'h7FFF_FFFF;
    localparam logic [15:0] HALF_SYNC    = 16'h7FFF;
    localparam logic [7:0]  NULL_ID_BYTE = 8'h01;
    localparam logic [6:0]  ID_MAX       = 7'h6F;
    localparam int          FRAME_BYTES  = 16;

    typedef enum logic [1:0] {
        B_EMPTY   = 2'd0,
        B_FILLING = 2'd1,
        B_CLOSED  = 2'd2
    } bld_state_t;

    // Source IDs 0 and 0x70..0x7F are reserved on the trace port.
    function automatic logic id_legal(input logic [6:0] id);
        return (id != 7'd0) && (id <= ID_MAX);
    endfunction

endpackage

// File: rtl/trace_frame_serializer.sv
// Shifts sync packets and 16-byte frames out as 4-bit nibbles and picks the
// next unit on the last nibble of the current one.
module trace_frame_serializer
    import trace_fmt_pkg::*;
#(
    parameter int pSYNC_FRAMES = 16
) (
    input  logic         target_clk,
    input  logic         resetn,
    input  logic [127:0] frame_data,
    input  logic         frame_ready,
    output logic         frame_take,
    output logic [3:0]   trace_data,
    output logic         frame_active
);

    localparam int SCW = $clog2(pSYNC_FRAMES + 1);

    logic [127:0]   shreg;
    logic [4:0]     nib_left;
    logic           started;
    logic [SCW-1:0] sync_cnt;
    logic           unit_end;
    logic           want_full;

    // Nothing is loaded until the first clock after reset, which counts as a
    // unit boundary and always starts with a full sync.
    assign unit_end   = !started || (nib_left == 5'd0);
    assign want_full  = !started || (sync_cnt == SCW'(pSYNC_FRAMES));
    assign frame_take = unit_end && !want_full && frame_ready;
    assign trace_data = shreg[3:0];

    // Unit selection at the boundary, otherwise shift one nibble per cycle.
    always_ff @(posedge target_clk or negedge resetn) begin
        if (!resetn) begin
            shreg        <= '0;
            nib_left     <= '0;
            started      <= 1'b0;
            sync_cnt     <= '0;
            frame_active <= 1'b0;
        end else if (unit_end) begin
            started <= 1'b1;
            if (want_full) begin
                shreg        <= {96'd0, FULL_SYNC};
                nib_left     <= 5'd7;
                sync_cnt     <= '0;
                frame_active <= 1'b0;
            end else if (frame_ready) begin
                shreg        <= frame_data;
                nib_left     <= 5'd31;
                sync_cnt     <= sync_cnt + SCW'(1);
                frame_active <= 1'b1;
            end else begin
                shreg        <= {112'd0, HALF_SYNC};
                nib_left     <= 5'd3;
                frame_active <= 1'b0;
            end
        end else begin
            shreg    <= shreg >> 4;
            nib_left <= nib_left - 5'd1;
        end
    end

endmodule

// File: rtl/trace_tpiu_formatter.sv
// TPIU parallel-trace transmitter: collects source-tagged bytes into a frame
// builder, pads and packs closed frames, and hands them to the serializer.
module trace_tpiu_formatter
    import trace_fmt_pkg::*;
#(
    parameter int pSYNC_FRAMES  = 16,
    parameter int pFLUSH_CYCLES = 64,
    parameter int pFLUSH_CNT_W  = 8
) (
    input  logic       target_clk,
    input  logic       resetn,
    input  logic [7:0] in_data,
    input  logic [6:0] in_id,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       flush,
    output logic [3:0] trace_data,
    output logic       O_frame_active,
    output logic       O_err_id
);

    bld_state_t              state;
    logic [14:0][7:0]        slots;
    logic [14:0]             is_id;
    logic [3:0]              k;
    logic [6:0]              cur_id;
    logic [pFLUSH_CNT_W-1:0] idle_cnt;
    logic                    live;
    logic                    err_q;

    logic                    legal;
    logic                    mismatch;
    logic                    accept;
    logic                    take_data;
    logic                    idle_done;
    logic                    frame_take;
    logic [FRAME_BYTES-1:0][7:0] frame;
    logic [7:0]              aux;

    assign legal     = id_legal(in_id);
    assign mismatch  = in_valid && legal && (state == B_FILLING) && (in_id != cur_id);
    assign in_ready  = live && (state != B_CLOSED) && !mismatch;
    assign accept    = in_valid && in_ready;
    assign take_data = accept && legal;
    assign idle_done = (state == B_FILLING) && !take_data &&
                       (idle_cnt == pFLUSH_CNT_W'(pFLUSH_CYCLES - 1));
    assign O_err_id  = err_q;

    // Builder: fill slots with raw bytes, close on full/mismatch/flush/idle.
    always_ff @(posedge target_clk or negedge resetn) begin
        if (!resetn) begin
            state    <= B_EMPTY;
            slots    <= '0;
            is_id    <= '0;
            k        <= '0;
            cur_id   <= '0;
            idle_cnt <= '0;
            live     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            live  <= 1'b1;
            err_q <= accept && !legal;
            case (state)
                B_EMPTY: begin
                    if (take_data) begin
                        slots[0] <= {in_id, 1'b1};
                        slots[1] <= in_data;
                        is_id    <= 15'd1;
                        k        <= 4'd2;
                        cur_id   <= in_id;
                        idle_cnt <= '0;
                        state    <= flush ? B_CLOSED : B_FILLING;
                    end
                end
                B_FILLING: begin
                    if (take_data) begin
                        slots[k] <= in_data;
                        k        <= k + 4'd1;
                        idle_cnt <= '0;
                        if (flush || (k == 4'd14))
                            state <= B_CLOSED;
                    end else if (mismatch || flush || idle_done) begin
                        idle_cnt <= '0;
                        state    <= B_CLOSED;
                    end else begin
                        idle_cnt <= idle_cnt + pFLUSH_CNT_W'(1);
                    end
                end
                B_CLOSED: begin
                    if (frame_take)
                        state <= B_EMPTY;
                end
                default: state <= B_EMPTY;
            endcase
        end
    end

    // Pack the held slots into TPIU layout: even data slots lose bit 0 to the
    // aux byte, then pad from the next free slot. An odd free slot means the
    // last data byte sits in an even slot; it moves up raw and a delayed-effect
    // null ID takes its place.
    always_comb begin
        frame = '0;
        aux   = '0;
        for (int s = 0; s < 15; s++) begin
            if (4'(s) < k) begin
                if (s[0] || is_id[s]) begin
                    frame[s] = slots[s];
                end else begin
                    frame[s]    = {slots[s][7:1], 1'b0};
                    aux[s >> 1] = slots[s][0];
                end
            end
        end
        if (k < 4'd15) begin
            if (!k[0]) begin
                frame[k] = NULL_ID_BYTE;
            end else begin
                frame[k - 4'd1] = NULL_ID_BYTE;
                frame[k]        = slots[k - 4'd1];
                aux[k[3:1]]     = 1'b1;
            end
        end
        frame[15] = aux;
    end

    trace_frame_serializer #(
        .pSYNC_FRAMES(pSYNC_FRAMES)
    ) u_ser (
        .target_clk  (target_clk),
        .resetn      (resetn),
        .frame_data  (frame),
        .frame_ready (state == B_CLOSED),
        .frame_take  (frame_take),
        .trace_data  (trace_data),
        .frame_active(O_frame_active)
    );

endmodule

// File: tb/tb_trace_tpiu_formatter.sv
// Directed bench for trace_tpiu_formatter: table of single-frame vectors plus
// hand sequences for ID switching, illegal IDs, forced sync and reset.
module tb_trace_tpiu_formatter;

    logic       target_clk = 1'b0;
    logic       resetn     = 1'b0;
    logic [7:0] in_data    = '0;
    logic [6:0] in_id      = '0;
    logic       in_valid   = 1'b0;
    logic       flush      = 1'b0;
    logic       in_ready;
    logic [3:0] trace_data;
    logic       O_frame_active;
    logic       O_err_id;

    trace_tpiu_formatter dut (
        .target_clk    (target_clk),
        .resetn        (resetn),
        .in_data       (in_data),
        .in_id         (in_id),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .flush         (flush),
        .trace_data    (trace_data),
        .O_frame_active(O_frame_active),
        .O_err_id      (O_err_id)
    );

    always #5 target_clk = ~target_clk;

    typedef logic [7:0] bytes16_t [16];
    typedef struct {
        int         nbytes;
        logic [7:0] data;
        logic [6:0] id;
        int         mode;   // 0 none, 1 flush with last byte, 2 flush after, 3 idle
        logic [127:0] exp;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] got_q [$];
    int           gap_q [$];
    int           last_run = 0;

    function automatic logic [127:0] frame_of(input bytes16_t b);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = b[i];
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Frame capture: nibble i of a frame lands at bits [4i+3:4i].
    initial begin
        logic [127:0] acc;
        int nib, run, gap;
        acc = '0; nib = 0; run = 0; gap = 0;
        forever begin
            @(negedge target_clk);
            if (!resetn) begin
                nib = 0; run = 0; gap = 0;
            end else if (O_frame_active) begin
                if (nib == 0) begin
                    gap_q.push_back(gap);
                    gap = 0;
                end
                acc[4*nib +: 4] = trace_data;
                nib++;
                run++;
                if (nib == 32) begin
                    got_q.push_back(acc);
                    nib = 0;
                end
            end else begin
                if (run != 0) last_run = run;
                run = 0;
                gap++;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the byte is taken.
    task automatic send(input logic [7:0] d, input logic [6:0] id, input logic fl, output int waited);
        logic ok;
        in_data = d; in_id = id; in_valid = 1'b1; flush = fl;
        waited = 0; ok = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            #1;
            if (in_ready) begin
                @(negedge target_clk);
                ok = 1'b1;
                break;
            end
            waited++;
            @(negedge target_clk);
        end
        in_valid = 1'b0; flush = 1'b0;
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic wait_frames(input int n, input string name);
        int t;
        for (t = 0; t < 3000 && got_q.size() < n; t++) @(negedge target_clk);
        if (got_q.size() < n) check(name, got_q.size(), n);
    endtask

    task automatic check_sync(input int nn, input logic [63:0] exp, input string name);
        logic [63:0] s;
        logic act;
        s = '0; act = 1'b0;
        for (int i = 0; i < nn; i++) begin
            @(negedge target_clk);
            s[4*i +: 4] = trace_data;
            act |= O_frame_active;
        end
        check(name, {act, s}, {1'b0, exp});
    endtask

    vec_t vecs [7];

    initial begin
        bytes16_t b;
        int w;
        int bad;

        b = '{8'h21,8'h55,8'h54,8'h55,8'h54,8'h55,8'h54,8'h55,8'h54,8'h55,8'h54,8'h55,8'h54,8'h55,8'h54,8'hFE};
        vecs[0] = '{14, 8'h55, 7'h10, 0, frame_of(b)};
        b = '{8'h21,8'h55,8'h54,8'h55,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h02};
        vecs[1] = '{3, 8'h55, 7'h10, 1, frame_of(b)};
        b = '{8'h21,8'h55,8'h01,8'h55,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h02};
        vecs[2] = '{2, 8'h55, 7'h10, 2, frame_of(b)};
        vecs[3] = '{2, 8'h55, 7'h10, 3, frame_of(b)};
        b = '{8'hDF,8'h3C,8'h3C,8'h3C,8'h01,8'h3C,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h04};
        vecs[4] = '{4, 8'h3C, 7'h6F, 2, frame_of(b)};
        b = '{8'h03,8'hFF,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};
        vecs[5] = '{1, 8'hFF, 7'h01, 2, frame_of(b)};
        b = '{8'h45,8'h81,8'h80,8'h81,8'h80,8'h81,8'h80,8'h81,8'h80,8'h81,8'h80,8'h81,8'h80,8'h81,8'h01,8'h7E};
        vecs[6] = '{13, 8'h81, 7'h22, 2, frame_of(b)};

        // Reset state and initial sync stream.
        repeat (3) @(negedge target_clk);
        check("reset_outputs", {trace_data, in_ready, O_frame_active, O_err_id}, 7'd0);
        resetn = 1'b1;
        check_sync(16, 64'h7FFF_7FFF_7FFF_FFFF, "initial_sync");

        // Table of single-frame vectors.
        for (int v = 0; v < 7; v++) begin
            got_q.delete();
            last_run = 0;
            for (int i = 0; i < vecs[v].nbytes; i++)
                send(vecs[v].data, vecs[v].id,
                     (vecs[v].mode == 1) && (i == vecs[v].nbytes - 1), w);
            if (vecs[v].mode == 2) begin
                flush = 1'b1;
                @(negedge target_clk);
                flush = 1'b0;
            end
            wait_frames(1, $sformatf("vec%0d_timeout", v));
            if (got_q.size() > 0) check($sformatf("vec%0d_frame", v), got_q[0], vecs[v].exp);
            repeat (2) @(negedge target_clk);
            check($sformatf("vec%0d_active_len", v), last_run, 32);
        end

        // ID switch closes the frame, the new byte waits; illegal ID is dropped.
        got_q.delete();
        send(8'h55, 7'h10, 1'b0, w);
        send(8'hAA, 7'h20, 1'b0, w);
        check("idswitch_ready_low", (w > 0), 1'b1);
        send(8'h33, 7'h00, 1'b0, w);
        check("err_id_pulse", O_err_id, 1'b1);
        @(negedge target_clk);
        check("err_id_clear", O_err_id, 1'b0);
        send(8'h44, 7'h70, 1'b0, w);
        check("err_id_0x70", O_err_id, 1'b1);
        flush = 1'b1;
        @(negedge target_clk);
        flush = 1'b0;
        wait_frames(2, "idswitch_timeout");
        b = '{8'h21,8'h55,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};
        if (got_q.size() > 0) check("frame_a", got_q[0], frame_of(b));
        b = '{8'h41,8'hAA,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};
        if (got_q.size() > 1) check("frame_b", got_q[1], frame_of(b));

        // Fresh reset so the sync counter starts at zero, then stream 18 frames.
        @(negedge target_clk);
        resetn = 1'b0;
        @(negedge target_clk);
        got_q.delete();
        gap_q.delete();
        resetn = 1'b1;
        for (int i = 0; i < 18 * 14; i++) send(8'h55, 7'h10, 1'b0, w);
        wait_frames(17, "stream_timeout");
        bad = 0;
        for (int i = 0; i < 17 && i < got_q.size(); i++)
            if (got_q[i] !== vecs[0].exp) bad++;
        check("stream_frames", bad, 0);
        bad = 0;
        for (int i = 1; i < 16 && i < gap_q.size(); i++)
            if (gap_q[i] != 0) bad++;
        check("stream_no_gaps", bad, 0);
        if (gap_q.size() > 16) check("full_sync_after_16", gap_q[16], 8);
        else check("full_sync_after_16_missing", gap_q.size(), 17);

        // Reset in the middle of a frame.
        for (int t = 0; t < 200 && !O_frame_active; t++) @(negedge target_clk);
        check("midframe_active", O_frame_active, 1'b1);
        repeat (5) @(negedge target_clk);
        #2 resetn = 1'b0;
        #1 check("midframe_reset_outputs", {trace_data, O_frame_active, in_ready, O_err_id}, 7'd0);
        @(negedge target_clk);
        resetn = 1'b1;
        check_sync(8, 64'h0000_0000_7FFF_FFFF, "post_reset_sync");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
